// File: rtl/hold_2_rx.sv
// Sink-end monitor for the hold_2 gate/toggle link: measures each gate burst, checks length and toggle.
// Optional HOLD_RX_SYNC_EN adds a 2-flop synchronizer on g_in/f_in (latencies +2 cycles).
module hold_2_rx #(
  parameter int CNT_W   = 4,
  parameter int EXP_LEN = 5,
  parameter int MAX_LEN = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_in,
  input  logic             f_in,
  output logic             frame_vld,
  output logic [CNT_W-1:0] frame_len,
  output logic             err_len,
  output logic             err_tgl,
  output logic             err_to,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, STUCK = 2'd2} state_t;

  logic g_s;
  logic f_s;

`ifdef HOLD_RX_SYNC_EN
  // bit 0 carries g, bit 1 carries f
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
    end else begin
      meta_reg <= {f_in, g_in};
      sync_reg <= meta_reg;
    end
  end

  assign g_s = sync_reg[0];
  assign f_s = sync_reg[1];
`else
  assign g_s = g_in;
  assign f_s = f_in;
`endif

  state_t           state_reg, state_next;
  logic             g_q_reg;
  logic             f_ref_reg, f_ref_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic             frame_vld_reg, frame_vld_next;
  logic [CNT_W-1:0] frame_len_reg, frame_len_next;
  logic             err_len_reg, err_len_next;
  logic             err_tgl_reg, err_tgl_next;
  logic             err_to_reg, err_to_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;

  logic             rise;
  logic [CNT_W-1:0] len_inc;

  assign rise    = g_s & ~g_q_reg;
  assign len_inc = len_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      g_q_reg       <= 1'b0;
      f_ref_reg     <= 1'b0;
      len_reg       <= '0;
      frame_vld_reg <= 1'b0;
      frame_len_reg <= '0;
      err_len_reg   <= 1'b0;
      err_tgl_reg   <= 1'b0;
      err_to_reg    <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      g_q_reg       <= g_s;
      f_ref_reg     <= f_ref_next;
      len_reg       <= len_next;
      frame_vld_reg <= frame_vld_next;
      frame_len_reg <= frame_len_next;
      err_len_reg   <= err_len_next;
      err_tgl_reg   <= err_tgl_next;
      err_to_reg    <= err_to_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    f_ref_next     = f_ref_reg;
    len_next       = len_reg;
    frame_vld_next = 1'b0;
    frame_len_next = frame_len_reg;
    err_len_next   = err_len_reg;
    err_tgl_next   = 1'b0;
    err_to_next    = 1'b0;
    frame_cnt_next = frame_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          len_next   = CNT_W'(1);
          state_next = GATE;
        end else if (f_s != f_ref_reg) begin
          err_tgl_next = 1'b1;
          f_ref_next   = f_s;
        end
      end
      GATE: begin
        if (g_s) begin
          len_next = len_inc;
          // A burst that reaches the timeout is abandoned, not reported as a frame
          if (len_inc == CNT_W'(MAX_LEN)) begin
            err_to_next = 1'b1;
            state_next  = STUCK;
          end
        end else begin
          frame_vld_next = 1'b1;
          frame_len_next = len_reg;
          err_len_next   = (len_reg != CNT_W'(EXP_LEN));
          err_tgl_next   = (f_s == f_ref_reg);
          f_ref_next     = f_s;
          frame_cnt_next = frame_cnt_reg + 8'd1;
          state_next     = IDLE;
        end
      end
      STUCK: begin
        // Resynchronise the toggle reference silently once the gate finally drops
        if (!g_s) begin
          f_ref_next = f_s;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_vld = frame_vld_reg;
  assign frame_len = frame_len_reg;
  assign err_len   = err_len_reg;
  assign err_tgl   = err_tgl_reg;
  assign err_to    = err_to_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_hold_2_rx.sv
// Scoreboard bench for hold_2_rx: burst-level reference model pushes expected pulses, a monitor pops them.
module tb_hold_2_rx;

  localparam int CNT_W   = 4;
  localparam int EXP_LEN = 5;
  localparam int MAX_LEN = 15;
`ifdef HOLD_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             rst;
  logic             g_in;
  logic             f_in;
  logic             frame_vld;
  logic [CNT_W-1:0] frame_len;
  logic             err_len;
  logic             err_tgl;
  logic             err_to;
  logic [7:0]       frame_cnt;

  hold_2_rx #(.CNT_W(CNT_W), .EXP_LEN(EXP_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .g_in      (g_in),
    .f_in      (f_in),
    .frame_vld (frame_vld),
    .frame_len (frame_len),
    .err_len   (err_len),
    .err_tgl   (err_tgl),
    .err_to    (err_to),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   t;
    bit   vld;
    bit   tgl;
    bit   to;
    int   len;
    bit   el;
    int   cnt;
  } ev_t;

  ev_t  exp_q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit         f_cur;
  bit         fref;
  logic [7:0] cnt_m;
  int         last_len;
  bit         last_el;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, edge_n);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (frame_vld || err_tgl || err_to)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got vld=%0b tgl=%0b to=%0b expected none (edge %0d)",
                 frame_vld, err_tgl, err_to, edge_n);
      end else begin
        e = exp_q.pop_front();
        $display("event edge=%0d vld=%0b tgl=%0b to=%0b len=%0d err_len=%0b cnt=%0d",
                 edge_n, frame_vld, err_tgl, err_to, frame_len, err_len, frame_cnt);
        chk("timing", edge_n, e.t);
        chk("pulses", int'({frame_vld, err_tgl, err_to}), int'({e.vld, e.tgl, e.to}));
        chk("frame_len", int'(frame_len), e.len);
        chk("err_len", int'(err_len), int'(e.el));
        chk("frame_cnt", int'(frame_cnt), e.cnt);
      end
    end
  end

  task automatic drive(input bit g, input bit f);
    g_in = g;
    f_in = f;
    @(posedge clk);
    #1;
  endtask

  // One gate burst of L high cycles followed by gap low cycles; expectations pushed up front
  task automatic burst(input int L, input bit tgl, input int gap, input bit idle_tgl);
    ev_t e;
    int  s;
    bit  f_new;
    s     = edge_n + 1;
    f_new = tgl ? ~f_cur : f_cur;
    if (L < MAX_LEN) begin
      cnt_m    = cnt_m + 8'd1;
      last_len = L;
      last_el  = (L != EXP_LEN);
      e = '{t: s + L + LAT, vld: 1'b1, tgl: (f_new == fref), to: 1'b0,
            len: last_len, el: last_el, cnt: int'(cnt_m)};
    end else begin
      e = '{t: s + MAX_LEN - 1 + LAT, vld: 1'b0, tgl: 1'b0, to: 1'b1,
            len: last_len, el: last_el, cnt: int'(cnt_m)};
    end
    exp_q.push_back(e);
    fref = f_new;
    if (idle_tgl && gap >= 2) begin
      fref = ~fref;
      e = '{t: s + L + 1 + LAT, vld: 1'b0, tgl: 1'b1, to: 1'b0,
            len: last_len, el: last_el, cnt: int'(cnt_m)};
      exp_q.push_back(e);
    end
    for (int i = 0; i < L; i++) drive(1'b1, f_cur);
    f_cur = f_new;
    drive(1'b0, f_cur);
    for (int j = 1; j < gap; j++) begin
      if (idle_tgl && j == 1) f_cur = ~f_cur;
      drive(1'b0, f_cur);
    end
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    chk({tag, "_frame_vld"}, int'(frame_vld), 0);
    chk({tag, "_frame_len"}, int'(frame_len), 0);
    chk({tag, "_err_len"}, int'(err_len), 0);
    chk({tag, "_err_tgl"}, int'(err_tgl), 0);
    chk({tag, "_err_to"}, int'(err_to), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    f_cur    = 1'b0;
    fref     = 1'b0;
    cnt_m    = 8'd0;
    last_len = 0;
    last_el  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int L;
    int gap;
    model_reset();
    rst  = 1'b1;
    g_in = 1'b0;
    f_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // reset during the third cycle of a gate: burst discarded
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    rst  = 1'b1;
    g_in = 1'b0;
    f_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("midgate_reset");
    rst = 1'b0;
    model_reset();

    // 256 clean frames one low cycle apart: count wraps back to 0
    for (int k = 0; k < 256; k++) burst(EXP_LEN, 1'b1, 1, 1'b0);
    chk("wrap_cnt", int'(frame_cnt), 0);

    burst(5, 1'b1, 3, 1'b0);   // clean frame
    burst(3, 1'b1, 2, 1'b0);   // short
    burst(7, 1'b1, 2, 1'b0);   // long
    burst(5, 1'b0, 4, 1'b1);   // missing toggle, then spurious toggle in idle
    burst(1, 1'b1, 2, 1'b0);   // glitch
    burst(14, 1'b1, 2, 1'b0);  // longest frame below timeout
    burst(15, 1'b1, 2, 1'b0);  // exactly the timeout
    burst(20, 1'b1, 2, 1'b0);  // stuck gate
    burst(5, 1'b1, 2, 1'b0);   // clean recovery

    for (int k = 0; k < 80; k++) begin
      L   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(1, 9));
      gap = int'($urandom_range(1, 4));
      burst(L, ($urandom_range(0, 4) != 0), gap, ($urandom_range(0, 3) == 0));
    end

    repeat (8) drive(1'b0, f_cur);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
